// File: rtl/pixel_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_word_packer
//  Description : Packs a stream of processed pixels into AXI-stream words with
//                start-of-frame (tuser), end-of-line (tlast) and per-lane keep
//                framing. A 2-entry output buffer absorbs downstream stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_word_packer #(
  parameter int PIXELSIZE       = 8,
  parameter int PIXELS_PER_WORD = 4,
  parameter int LINE_PIXELS     = 512,
  parameter int FRAME_LINES     = 512
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 pixel_in_valid,
  input  logic [PIXELSIZE-1:0]                 pixel_in,
  output logic                                 pixel_in_ready,
  output logic [PIXELSIZE*PIXELS_PER_WORD-1:0] m_tdata,
  output logic [PIXELS_PER_WORD-1:0]           m_tkeep,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic                                 m_tlast,
  output logic                                 m_tuser,
  output logic                                 frame_done
);

  localparam int c_word_w = PIXELSIZE * PIXELS_PER_WORD;
  localparam int c_col_w  = (LINE_PIXELS > 1)     ? $clog2(LINE_PIXELS)     : 1;
  localparam int c_row_w  = (FRAME_LINES > 1)     ? $clog2(FRAME_LINES)     : 1;
  localparam int c_lane_w = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;

  localparam logic [c_col_w-1:0]  c_last_col  = c_col_w'(LINE_PIXELS - 1);
  localparam logic [c_row_w-1:0]  c_last_row  = c_row_w'(FRAME_LINES - 1);
  localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(PIXELS_PER_WORD - 1);

  // One buffered output word together with its framing.
  // fend marks the final word of a frame so its pop can raise frame_done.
  typedef struct packed {
    logic [c_word_w-1:0]        data;
    logic [PIXELS_PER_WORD-1:0] keep;
    logic                       last;
    logic                       user;
    logic                       fend;
  } entry_t;

  // Position and assembly state
  logic [c_col_w-1:0]  col_q,  col_d;
  logic [c_row_w-1:0]  row_q,  row_d;
  logic [c_lane_w-1:0] lane_q, lane_d;
  logic [c_word_w-1:0] asm_q,  asm_d;
  logic                user_q, user_d;

  // Output buffer: head drives the m_* ports, tail is the second slot
  entry_t      head_q, tail_q;
  logic [1:0]  cnt_q;
  logic        frame_done_q;

  // Combinational helpers
  logic                       w_accept;
  logic                       w_eol;
  logic                       w_word_done;
  logic                       w_pop;
  logic                       w_at_origin;
  logic [c_word_w-1:0]        w_word;
  logic [PIXELS_PER_WORD-1:0] w_keep;
  entry_t                     w_new;

  assign pixel_in_ready = !rst && (cnt_q < 2'd2);
  assign w_accept       = pixel_in_valid && pixel_in_ready;
  assign w_eol          = (col_q == c_last_col);
  assign w_word_done    = w_accept && ((lane_q == c_last_lane) || w_eol);
  assign w_pop          = m_tvalid && m_tready;
  assign w_at_origin    = (col_q == '0) && (row_q == '0);

  // Current pixel dropped into its lane; lanes up to the current one are real.
  // Lanes above the current one are still zero since the assembly register
  // is cleared whenever a word leaves it.
  for (genvar g = 0; g < PIXELS_PER_WORD; g++) begin : g_lane
    assign w_word[g*PIXELSIZE +: PIXELSIZE] =
      (lane_q == c_lane_w'(g)) ? pixel_in : asm_q[g*PIXELSIZE +: PIXELSIZE];
    assign w_keep[g] = (c_lane_w'(g) <= lane_q);
  end

  // Build the buffer entry for a word completed this cycle
  always_comb begin
    w_new      = '0;
    w_new.data = w_word;
    w_new.keep = w_keep;
    w_new.last = w_eol;
    w_new.user = user_q || w_at_origin;
    w_new.fend = w_eol && (row_q == c_last_row);
  end

  // Next-state for column/row counters, lane index and the assembly register
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    lane_d = lane_q;
    asm_d  = asm_q;
    user_d = user_q;
    if (w_accept) begin
      if (w_eol) begin
        col_d = '0;
        row_d = (row_q == c_last_row) ? '0 : row_q + c_row_w'(1);
      end else begin
        col_d = col_q + c_col_w'(1);
      end
      if (w_word_done) begin
        lane_d = '0;
        asm_d  = '0;
        user_d = 1'b0;
      end else begin
        lane_d = lane_q + c_lane_w'(1);
        asm_d  = w_word;
        user_d = user_q || w_at_origin;
      end
    end
  end

  // Position and assembly registers
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      lane_q <= '0;
      asm_q  <= '0;
      user_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      lane_q <= lane_d;
      asm_q  <= asm_d;
      user_q <= user_d;
    end
  end

  // Two-entry output buffer; a push never meets a full buffer because the
  // input stalls whenever both slots are occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({w_word_done, w_pop})
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= w_new;
          end else begin
            head_q <= tail_q;
            tail_q <= w_new;
          end
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_q <= w_new;
          end else begin
            tail_q <= w_new;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

  // One-cycle pulse after the final word of a frame leaves the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= w_pop && head_q.fend;
    end
  end

  assign m_tvalid   = (cnt_q != 2'd0);
  assign m_tdata    = head_q.data;
  assign m_tkeep    = head_q.keep;
  assign m_tlast    = head_q.last;
  assign m_tuser    = head_q.user;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_word_packer
//  Description : Self-checking bench for pixel_word_packer (4 pixels/word,
//                6-pixel lines, 2-line frames) against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_word_packer;

  localparam int PS = 8;
  localparam int P  = 4;
  localparam int L  = 6;
  localparam int F  = 2;
  localparam int W  = PS * P;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pixel_in_valid = 1'b0;
  logic [PS-1:0] pixel_in = '0;
  logic          pixel_in_ready;
  logic [W-1:0]  m_tdata;
  logic [P-1:0]  m_tkeep;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          m_tuser;
  logic          frame_done;

  always #5 clk = ~clk;

  pixel_word_packer #(
    .PIXELSIZE      (PS),
    .PIXELS_PER_WORD(P),
    .LINE_PIXELS    (L),
    .FRAME_LINES    (F)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pixel_in_valid(pixel_in_valid),
    .pixel_in      (pixel_in),
    .pixel_in_ready(pixel_in_ready),
    .m_tdata       (m_tdata),
    .m_tkeep       (m_tkeep),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tlast       (m_tlast),
    .m_tuser       (m_tuser),
    .frame_done    (frame_done)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic [P-1:0] keep;
    logic         last;
    logic         user;
    logic         fend;
  } word_t;

  word_t         mq[$];     // words the packer should currently hold, in order
  word_t         obs[$];    // words actually popped from the DUT
  logic [PS-1:0] grp[$];    // pixels of the word being assembled
  logic          grp_user;
  int            n;         // pixels accepted since reset
  logic          fd_exp = 1'b0;
  logic          last_acc = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            user_seen = 0;
  int            fd_seen = 0;
  int            keep_bits = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Pixel n sits at col n%L of row (n/L)%F; a word closes after P pixels
  // or at the end of a line.
  task automatic model_accept(input logic [PS-1:0] pix);
    int    col;
    int    row;
    word_t w;
    col = n % L;
    row = (n / L) % F;
    if (grp.size() == 0) grp_user = (col == 0) && (row == 0);
    grp.push_back(pix);
    n++;
    if (grp.size() == P || col == L - 1) begin
      w = '0;
      foreach (grp[i]) w.data[i*PS +: PS] = grp[i];
      w.keep = P'((1 << grp.size()) - 1);
      w.last = (col == L - 1);
      w.user = grp_user;
      w.fend = (col == L - 1) && (row == F - 1);
      mq.push_back(w);
      grp.delete();
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model
  task automatic cycle();
    word_t         h;
    word_t         o;
    logic          acc;
    logic          pop;
    logic [PS-1:0] pix;
    @(negedge clk);
    chk("ready", pixel_in_ready, !rst && (mq.size() < 2));
    chk("tvalid", m_tvalid, mq.size() != 0);
    if (mq.size() != 0) begin
      h = mq[0];
      chk("tdata", m_tdata, h.data);
      chk("tkeep", m_tkeep, h.keep);
      chk("tlast", m_tlast, h.last);
      chk("tuser", m_tuser, h.user);
    end
    chk("frame_done", frame_done, fd_exp);
    acc = !rst && pixel_in_valid && (mq.size() < 2);
    pop = !rst && m_tready && (mq.size() != 0);
    if (pop) begin
      o      = '0;
      o.data = m_tdata;
      o.keep = m_tkeep;
      o.last = m_tlast;
      o.user = m_tuser;
      obs.push_back(o);
      if (m_tuser) user_seen++;
      keep_bits += $countones(m_tkeep);
    end
    if (frame_done === 1'b1) fd_seen++;
    pix = pixel_in;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      grp.delete();
      n      = 0;
      fd_exp = 1'b0;
    end else begin
      fd_exp = pop && mq[0].fend;
      if (pop) void'(mq.pop_front());
      if (acc) model_accept(pix);
    end
    last_acc = acc;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, pixel_in_ready, 0);
    chk({tag, "_tvalid"}, m_tvalid, 0);
    chk({tag, "_tdata"}, m_tdata, 0);
    chk({tag, "_tkeep"}, m_tkeep, 0);
    chk({tag, "_tlast"}, m_tlast, 0);
    chk({tag, "_tuser"}, m_tuser, 0);
    chk({tag, "_fdone"}, frame_done, 0);
  endtask

  logic [31:0] s1_data [4] = '{32'h04030201, 32'h00000605, 32'h0A090807, 32'h00000C0B};
  logic [3:0]  s1_keep [4] = '{4'b1111, 4'b0011, 4'b1111, 4'b0011};
  logic        s1_last [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic        s1_user [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int v;
    int base;
    int sent;
    int budget;

    // Reset state
    n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Scenario 1: one frame, no back-pressure
    m_tready = 1'b1;
    obs.delete();
    for (int i = 1; i <= 12; i++) begin
      pixel_in_valid = 1'b1;
      pixel_in       = PS'(i);
      cycle();
    end
    pixel_in_valid = 1'b0;
    repeat (4) cycle();
    chk("s1_words", obs.size(), 4);
    if (obs.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("s1_data%0d", i), obs[i].data, s1_data[i]);
        chk($sformatf("s1_keep%0d", i), obs[i].keep, s1_keep[i]);
        chk($sformatf("s1_last%0d", i), obs[i].last, s1_last[i]);
        chk($sformatf("s1_user%0d", i), obs[i].user, s1_user[i]);
      end
    end
    chk("s1_fdone", fd_seen, 1);

    // Scenario 2: back-pressure with continuous input, then drain
    m_tready = 1'b0;
    v = 1;
    for (int i = 0; i < 12; i++) begin
      pixel_in_valid = 1'b1;
      pixel_in       = PS'(v);
      cycle();
      if (last_acc) v++;
    end
    chk("s2_ready_low", pixel_in_ready, 0);
    chk("s2_hold_data", m_tdata, 32'h04030201);
    m_tready = 1'b1;
    budget = 0;
    while (v <= 12 && budget < 100) begin
      pixel_in_valid = 1'b1;
      pixel_in       = PS'(v);
      cycle();
      if (last_acc) v++;
      budget++;
    end
    chk("s2_timeout", v, 13);
    pixel_in_valid = 1'b0;
    repeat (6) cycle();
    chk("s2_fdone", fd_seen, 2);

    // Scenario 3: push and pop on the same edge with one entry buffered
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pixel_in_valid = 1'b1;
      pixel_in       = PS'(8'h21 + i);
      cycle();
    end
    pixel_in = 8'h26;
    m_tready = 1'b1;
    cycle();
    chk("s3_tvalid", m_tvalid, 1);
    chk("s3_ready", pixel_in_ready, 1);
    chk("s3_tdata", m_tdata, 32'h00002625);
    chk("s3_tkeep", m_tkeep, 4'b0011);
    for (int i = 0; i < 6; i++) begin
      pixel_in = PS'($urandom);
      cycle();
    end
    pixel_in_valid = 1'b0;
    repeat (4) cycle();
    chk("s3_fdone", fd_seen, 3);

    // Scenario 4: reset after three pixels of a frame
    for (int i = 0; i < 3; i++) begin
      pixel_in_valid = 1'b1;
      pixel_in       = PS'(8'h31 + i);
      cycle();
    end
    rst      = 1'b1;
    pixel_in = 8'hEE;
    cycle();
    check_all_zero("s4_rst");
    rst  = 1'b0;
    base = obs.size();
    for (int i = 0; i < 6; i++) begin
      pixel_in_valid = 1'b1;
      pixel_in       = PS'(8'h41 + i);
      cycle();
    end
    pixel_in_valid = 1'b0;
    repeat (4) cycle();
    chk("s4_words", obs.size() - base, 2);
    if (obs.size() - base == 2) begin
      chk("s4_w0_data", obs[base].data, 32'h44434241);
      chk("s4_w0_user", obs[base].user, 1);
      chk("s4_w1_data", obs[base+1].data, 32'h00004645);
      chk("s4_w1_keep", obs[base+1].keep, 4'b0011);
      chk("s4_w1_user", obs[base+1].user, 0);
    end

    // Scenario 5: two frames with random valid/ready gaps
    rst = 1'b1;
    cycle();
    rst       = 1'b0;
    user_seen = 0;
    fd_seen   = 0;
    keep_bits = 0;
    sent      = 0;
    budget    = 0;
    while ((sent < 24 || mq.size() != 0) && budget < 2000) begin
      pixel_in_valid = (sent < 24) && ($urandom_range(0, 3) != 0);
      pixel_in       = PS'($urandom);
      m_tready       = ($urandom_range(0, 2) != 0);
      cycle();
      if (last_acc) sent++;
      budget++;
    end
    chk("s5_timeout", budget < 2000, 1);
    pixel_in_valid = 1'b0;
    m_tready       = 1'b1;
    repeat (3) cycle();
    chk("s5_tuser_count", user_seen, 2);
    chk("s5_fdone_count", fd_seen, 2);
    chk("s5_keep_bits", keep_bits, 24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/pixel_word_packer.md
# pixel_word_packer

Output-side packer for the blur pipeline. It sits directly downstream of the image-processing top level and drains that stage's output FIFO through its valid/ready pair. Each group of `pixels_per_word` processed 8-bit pixels becomes one word on an AXI-stream master, with start-of-frame, end-of-line and byte-keep framing, for a DMA or host link. A 2-entry output buffer absorbs downstream back-pressure without losing pixels.

## Interface
- `pixelsize`, 8: bits per pixel.
- `pixels_per_word`, 4: pixels packed per output word. Legal range 1..8.
- `line_pixels`, 512: pixels per image line arriving from the pipeline. Need not be a multiple of `pixels_per_word`.
- `frame_lines`, 512: lines per frame.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `pixel_in_valid`  in  1  pixel available; connects to the top level's `pixel_out_valid`.
- `pixel_in`  in  `pixelsize`  processed pixel; connects to `output_pixel`.
- `pixel_in_ready`  out  1  pixel accepted this cycle when high with `pixel_in_valid`; drives the top level's `pixel_input_ready`.
- `m_tdata`  out  `pixelsize*pixels_per_word`  packed word; pixel 0 of the group is in the LSBs.
- `m_tkeep`  out  `pixels_per_word`  one bit per pixel lane, 1 = lane holds a real pixel.
- `m_tvalid`  out  1  word valid.
- `m_tready`  in  1  downstream accepts the word.
- `m_tlast`  out  1  word carries the last pixel of a line.
- `m_tuser`  out  1  word carries pixel (0,0) of a frame.
- `frame_done`  out  1  one-cycle pulse after the last word of a frame is transferred.

## Operation
- **Pixel accept:** a pixel is accepted on a cycle where `pixel_in_valid && pixel_in_ready`.
  - It is written to lane `col mod pixels_per_word` of the assembly register.
  - `col` (0..`line_pixels`-1) and `row` (0..`frame_lines`-1) then advance.
- **Counter wrap:**
  - `col` wraps to 0 after `line_pixels`-1, and on that wrap `row` increments.
  - `row` wraps to 0 after `frame_lines`-1.
- **Word completion:** a word completes when the accepted pixel fills lane `pixels_per_word`-1, or is the last pixel of a line (`col == line_pixels-1`).
  - The completed word, with its `tkeep`, `tlast` and `tuser`, is pushed into the output buffer.
  - The assembly register clears.
- **Partial final word:** when `line_pixels mod pixels_per_word = r ≠ 0`, the final word of each line carries `r` real lanes.
  - Those lanes have `m_tkeep` = 1; the remaining lanes are zero-filled with `m_tkeep` = 0.
  - Full words always carry `m_tkeep` all-ones.
- **Start of frame:** `m_tuser` is 1 only on the word containing `row=0, col=0`.
- **Output buffer:** 2-entry FIFO.
  - The head entry drives the `m_*` outputs.
  - A pop occurs on `m_tvalid && m_tready`.
  - Push and pop in the same cycle are both honoured, and the occupancy is unchanged.
- **Input back-pressure:** `pixel_in_ready` = `!rst && (occupancy < 2)`.
  - This is conservative: it deasserts whenever the buffer is full, even when the next pixel would not complete a word.
- **Output hold:** while `m_tvalid && !m_tready`, every `m_*` output holds stable.
- **Frame done:** `frame_done` pulses when the word with `tlast=1` and `row = frame_lines-1` is popped.
- **Reset:** `rst` high, including mid-frame, does the following on that clock edge:
  - discards the assembly register and both buffer entries;
  - zeroes `col` and `row`;
  - drives every output low (`pixel_in_ready`=0, `m_tvalid`=0, `m_tdata`=0, `m_tkeep`=0, `m_tlast`=0, `m_tuser`=0, `frame_done`=0).
  - The first pixel accepted after reset is treated as (0,0).

## Timing
- **Latency:** a word-completing pixel accepted on edge N gives `m_tvalid` high after edge N, when the buffer was empty. Latency is 1 cycle.
- **Throughput:** 1 pixel/cycle sustained when `m_tready` is held high. `m_tvalid` is then high 1 cycle in every `pixels_per_word`, plus one extra word per line for a partial final word.
- **Buffer full:** when the buffer is full, `pixel_in_ready` is low the same cycle, combinationally from the occupancy register. The pixel upstream is held by the FIFO and no pixel is lost.
- **Ready after a pop:** a pop on edge N raises `pixel_in_ready` after edge N.
- **`frame_done` timing:** asserted for exactly the one cycle following the popping edge.
- **Reset timing:** `pixel_in_ready` rises in the first cycle after the last cycle with `rst` high.

## Test plan
Parameters for all scenarios: `pixels_per_word`=4, `line_pixels`=6, `frame_lines`=2.

1. **Frame packing, no back-pressure.** Stream pixels 0x01..0x0C, `m_tready`=1. Required words, in order:
   - `0x04030201` keep `1111` user=1 last=0;
   - `0x00000605` keep `0011` last=1;
   - `0x0A090807` keep `1111` user=0;
   - `0x00000C0B` keep `0011` last=1;
   - then `frame_done` for one cycle.
2. **Back-pressure.** `m_tready`=0 with continuous input.
   - After 2 words are buffered, `pixel_in_ready`=0 and `m_tdata` stays `0x04030201`.
   - Raise `m_tready`: words drain in order, and no pixel is duplicated or dropped.
3. **Simultaneous push and pop.** Buffer at 1 entry; a word completes on the same edge as a pop.
   - Occupancy stays 1, and `m_tdata` shows the new word on the next cycle.
4. **Reset mid-frame.** Assert `rst` for 1 cycle after 3 pixels of frame 0.
   - All outputs are 0 during reset.
   - The next 6 pixels produce words with `m_tuser`=1 on the first word, and no stale lanes.
5. **Two back-to-back frames with random valid/ready gaps.**
   - `m_tuser` is seen exactly twice and `frame_done` exactly twice.
   - Total keep-bit count is 24.
